mdu_iter: RTL
=============

Name: mdu_iter

Overview:
- Multi-cycle multiply/divide unit with its own HI/LO registers.
- Takes MULT/MULTU/DIV/DIVU/MTHI/MTLO out of the single-cycle ALU path, so the long divide no longer sets the critical path.
- Sits beside the execute stage. The pipeline holds the issuing instruction while `busy` is high, and reads HI/LO combinationally for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be at least 4.
- MUL_STAGES, 2, multiply latency in cycles (1..4); the product is registered through MUL_STAGES stages.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept an operation.
- op  in  4  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-9 reserved for MDU_MADD_EN; all other codes are no-ops.
- a  in  WIDTH  rs operand.
- b  in  WIDTH  rt operand.
- flush  in  1  cancel the in-flight operation (exception or branch squash).
- busy  out  1  an operation is in flight.
- done  out  1  one-cycle pulse: HI/LO were updated on the preceding edge.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, resetn=0): hi=0, lo=0, state=IDLE, busy=0, done=0, in_ready=1. All iteration counters and datapath registers are cleared. Reset mid-operation abandons the operation with no HI/LO write.
- Handshake:
  - An operation is accepted on a rising edge where in_valid & in_ready & !flush.
  - in_ready = (state==IDLE).
  - busy = !(state==IDLE).
  - a, b and op are captured at acceptance; later input changes are ignored.
- States:
  - IDLE: MULT/MULTU go to MUL; DIV/DIVU go to DIV; MTHI/MTLO and no-op codes stay in IDLE.
  - MUL: counts MUL_STAGES-1 cycles, then writes HI/LO and returns to IDLE.
  - DIV: WIDTH iterations of restoring radix-2 divide on operand magnitudes, then goes to FIX.
  - FIX: applies sign correction, writes HI/LO and returns to IDLE.
- Latency, counted from the accepting edge = edge 0:
  - MTHI/MTLO write at edge 0.
  - MULT/MULTU write at edge MUL_STAGES.
  - DIV/DIVU write at edge WIDTH+1.
  - done is high for exactly the cycle after the write edge, for every accepted operation except no-ops.
- Multiply: the 2*WIDTH product goes to {hi, lo}. MULT sign-extends both operands; MULTU zero-extends them.
- Divide:
  - lo = quotient, hi = remainder.
  - Signed: the quotient truncates toward zero; the remainder takes the sign of the dividend.
  - b=0 (either mode): lo = all ones, hi = a. Still takes the full WIDTH+1 cycles.
  - DIV with a = most-negative and b = -1: lo = a, hi = 0.
- MTHI writes hi=a; MTLO writes lo=a. The other register is unchanged.
- HI/LO change only at the defined write edges. hi/lo outputs hold their old values throughout MUL/DIV/FIX.
- flush:
  - In IDLE it blocks acceptance.
  - In any other state it forces IDLE at the next edge; no HI/LO write and no done pulse.
  - flush together with in_valid in IDLE: the request is dropped.
  - flush on the same edge as a HI/LO write: flush wins and the write is suppressed.
- Back-to-back: in_ready is high in the cycle after a write edge, so a new operation may be accepted in the same cycle done is high.

Optional Feature:
- Macro: MDU_MADD_EN.
- When defined, enables four multiply-accumulate ops, all with MUL_STAGES latency:
  - op 6 MADD: {hi,lo} += signed product.
  - op 7 MADDU: {hi,lo} += unsigned product.
  - op 8 MSUB: {hi,lo} -= signed product.
  - op 9 MSUBU: {hi,lo} -= unsigned product.
- Accumulation is modulo 2^(2*WIDTH), using the HI/LO value present at the write edge.
- When not defined, ops 6-9 are no-ops: accepted, no state change, no done pulse, and no accumulator adder is synthesized.

Test Plan:
- Reset: hold resetn=0 mid-DIV → hi=lo=0, busy=0, in_ready=1 immediately; no done pulse after release.
- MULT a=0xFFFFFFFE (-2), b=3 → at edge 2: hi=0xFFFFFFFF, lo=0xFFFFFFFA; done high 1 cycle. MULTU same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7, b=2 → hi/lo unchanged until edge 33, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); busy high for edges 0..32. DIVU a=7, b=2 → lo=3, hi=1.
- Corner divides: DIVU a=5, b=0 → lo=0xFFFFFFFF, hi=5. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Flush: issue DIV, assert flush at edge 10 → busy=0 next cycle, hi/lo keep prior values, no done. Next, issue MTLO a=0x1234 in the same cycle as flush → dropped, lo unchanged.
- With MDU_MADD_EN: MTHI 0, MTLO 0xFFFFFFFF, then MADDU a=1, b=1 → hi=1, lo=0. MSUB a=1, b=1 → hi=0, lo=0xFFFFFFFF. Without the macro, the same op sequence leaves hi/lo unchanged by ops 6-9.

Source files
------------

// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide unit with private HI/LO; multiply is pipelined, divide is restoring radix-2.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU accumulate ops (6-9); otherwise those codes are no-ops.
//
// state | meaning
// IDLE  | ready for a new op; MTHI/MTLO write here
// MUL   | product flowing through the multiply pipeline
// DIV   | one quotient bit per cycle on operand magnitudes
// FIX   | sign correction and HI/LO write of the divide result
module mdu_iter #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(MUL_STAGES - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t state, state_nxt;

  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, b_mag, quo, rem;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod_pipe [MUL_STAGES];

  logic               accept, div_step, wr_hi, wr_lo;
  logic [WIDTH-1:0]   hi_nxt, lo_nxt;
  logic               op_is_mul, op_is_div, op_mul_signed, op_div_signed;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod_in, prod_last, mul_res;
  logic [WIDTH-1:0]   a_mag_in, b_mag_in;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic               div_signed_q, q_neg, r_neg, div_by_zero;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  always_comb begin
    op_is_div     = (op == OP_DIV) || (op == OP_DIVU);
    op_div_signed = (op == OP_DIV);
    op_is_mul     = (op == OP_MULT) || (op == OP_MULTU);
    op_mul_signed = (op == OP_MULT);
`ifdef MDU_MADD_EN
    op_is_mul     = op_is_mul || (op == OP_MADD) || (op == OP_MADDU) ||
                    (op == OP_MSUB) || (op == OP_MSUBU);
    op_mul_signed = op_mul_signed || (op == OP_MADD) || (op == OP_MSUB);
`endif
  end

  assign a_ext    = op_mul_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign b_ext    = op_mul_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
  assign prod_in  = a_ext * b_ext;
  assign a_mag_in = (op_div_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag_in = (op_div_signed && b[WIDTH-1]) ? -b : b;

  assign prod_last = prod_pipe[MUL_STAGES-1];

  always_comb begin
    mul_res = prod_last;
`ifdef MDU_MADD_EN
    case (op_q)
      OP_MADD, OP_MADDU: mul_res = {hi, lo} + prod_last;
      OP_MSUB, OP_MSUBU: mul_res = {hi, lo} - prod_last;
      default:           mul_res = prod_last;
    endcase
`endif
  end

  // rem < b_mag holds between steps, so bit WIDTH of the difference is the borrow
  assign rem_sh   = {rem, quo[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, b_mag};

  assign div_signed_q = (op_q == OP_DIV);
  assign div_by_zero  = (b_q == '0);
  assign q_neg        = div_signed_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
  assign r_neg        = div_signed_q && a_q[WIDTH-1];
  assign quo_fix      = q_neg ? -quo : quo;
  assign rem_fix      = r_neg ? -rem : rem;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    div_step  = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    hi_nxt    = hi;
    lo_nxt    = lo;
    case (state)
      S_IDLE: begin
        if (in_valid && !flush) begin
          accept = 1'b1;
          if (op_is_mul) state_nxt = S_MUL;
          else if (op_is_div) state_nxt = S_DIV;
          else if (op == OP_MTHI) begin
            wr_hi  = 1'b1;
            hi_nxt = a;
          end else if (op == OP_MTLO) begin
            wr_lo  = 1'b1;
            lo_nxt = a;
          end
        end
      end
      S_MUL: begin
        if (flush) state_nxt = S_IDLE;
        else if (cnt == '0) begin
          wr_hi            = 1'b1;
          wr_lo            = 1'b1;
          {hi_nxt, lo_nxt} = mul_res;
          state_nxt        = S_IDLE;
        end
      end
      S_DIV: begin
        if (flush) state_nxt = S_IDLE;
        else begin
          div_step = 1'b1;
          if (cnt == '0) state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        if (!flush) begin
          wr_hi  = 1'b1;
          wr_lo  = 1'b1;
          hi_nxt = div_by_zero ? a_q : rem_fix;
          lo_nxt = div_by_zero ? '1  : quo_fix;
        end
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      b_mag <= '0;
      quo   <= '0;
      rem   <= '0;
      cnt   <= '0;
      for (int i = 0; i < MUL_STAGES; i++) prod_pipe[i] <= '0;
    end else begin
      for (int i = 1; i < MUL_STAGES; i++) prod_pipe[i] <= prod_pipe[i-1];
      if (accept) begin
        op_q         <= op;
        a_q          <= a;
        b_q          <= b;
        b_mag        <= b_mag_in;
        quo          <= a_mag_in;
        rem          <= '0;
        cnt          <= op_is_div ? CNT_DIV : CNT_MUL;
        prod_pipe[0] <= prod_in;
      end else begin
        if (state != S_IDLE && cnt != '0) cnt <= cnt - CNT_W'(1);
        if (div_step) begin
          if (!rem_diff[WIDTH]) begin
            rem <= rem_diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      if (wr_hi) hi <= hi_nxt;
      if (wr_lo) lo <= lo_nxt;
      done <= wr_hi || wr_lo;
    end
  end

endmodule
